// File: rtl/aim65_ram_arbiter.sv
// Shares the synchronous system RAM between the 65C02 and the host loader port.
// Optional host write checksum: define AIM65_RAM_ARB_CSUM_EN.
module aim65_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int CPU_SLOTS  = 2
) (
  input  logic                  cpu_clk,
  input  logic                  reset,
  input  logic                  cpu_cs,
  input  logic                  cpu_rw,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rdy,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_hold,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_owns,
  output logic                  ram_cs,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [15:0]           host_csum
);

  localparam int CNT_W = (CPU_SLOTS < 1) ? 1 : $clog2(CPU_SLOTS + 1);
  localparam logic [CNT_W-1:0] SLOT_MAX = CNT_W'(CPU_SLOTS);

  typedef enum logic [2:0] {
    S_CPU,
    S_STALL,
    S_HOST,
    S_HDONE,
    S_HIDLE,
    S_REPLAY
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] slot_cnt;
  logic             req_armed;
  logic             host_read_q;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      S_CPU:    if (host_req && req_armed && slot_cnt == SLOT_MAX) state_d = S_STALL;
      S_STALL:  state_d = S_HOST;
      S_HOST:   state_d = S_HDONE;
      S_HDONE:  state_d = host_hold ? S_HIDLE : S_REPLAY;
      S_HIDLE: begin
        if (host_req && req_armed) state_d = S_HOST;
        else if (!host_hold)       state_d = S_REPLAY;
      end
      S_REPLAY: state_d = S_CPU;
      default:  state_d = S_CPU;
    endcase
  end

  // REPLAY re-reads the held CPU address; a pending CPU write commits later in S_CPU.
  always_comb begin
    ram_cs   = 1'b0;
    ram_rw   = 1'b1;
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;
    case (state)
      S_CPU: begin
        ram_cs = cpu_cs;
        ram_rw = cpu_rw;
      end
      S_HOST: begin
        ram_cs   = 1'b1;
        ram_rw   = ~host_we;
        ram_addr = host_addr;
        ram_din  = host_wdata;
      end
      S_REPLAY: ram_cs = cpu_cs;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state       <= S_CPU;
      cpu_rdy     <= 1'b1;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      host_owns   <= 1'b0;
      slot_cnt    <= SLOT_MAX;
      req_armed   <= 1'b1;
      host_read_q <= 1'b0;
    end else begin
      state     <= state_d;
      cpu_rdy   <= (state == S_CPU);
      host_owns <= (state != S_CPU);
      host_ack  <= (state == S_HDONE);

      if (state == S_HOST) host_read_q <= ~host_we;
      if (state == S_HDONE && host_read_q) host_rdata <= ram_dout;

      if (state == S_REPLAY)
        slot_cnt <= '0;
      else if (state == S_CPU && slot_cnt != SLOT_MAX)
        slot_cnt <= slot_cnt + CNT_W'(1);

      // A request still high after its ack must drop before it can be served again.
      if (!host_req)
        req_armed <= 1'b1;
      else if (state == S_HDONE)
        req_armed <= 1'b0;
    end
  end

`ifdef AIM65_RAM_ARB_CSUM_EN
  logic        hold_q;
  logic [15:0] csum_q;

  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      hold_q <= 1'b0;
      csum_q <= 16'h0000;
    end else begin
      hold_q <= host_hold;
      if (host_hold && !hold_q)
        csum_q <= 16'h0000;
      else if (state == S_HOST && host_we)
        csum_q <= csum_q + 16'(host_wdata);
    end
  end

  assign host_csum = csum_q;
`else
  assign host_csum = 16'h0000;
`endif

endmodule

// File: tb/tb_aim65_ram_arbiter.sv
// Directed bench for aim65_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_aim65_ram_arbiter;

  logic        cpu_clk;
  logic        reset;
  logic        cpu_cs;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic        host_req;
  logic        host_we;
  logic [14:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_hold;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_owns;
  logic        ram_cs;
  logic        ram_rw;
  logic [14:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [15:0] host_csum;

  int errors = 0;
  int checks = 0;

  aim65_ram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .CPU_SLOTS(2)) dut (
    .cpu_clk   (cpu_clk),
    .reset     (reset),
    .cpu_cs    (cpu_cs),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdy   (cpu_rdy),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_hold (host_hold),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .host_owns (host_owns),
    .ram_cs    (ram_cs),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .host_csum (host_csum)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Synchronous RAM model; wcount tallies every committed write.
  logic [7:0] mem [0:32767];
  int wcount = 0;
  always @(posedge cpu_clk) begin
    if (ram_cs) begin
      if (ram_rw) ram_dout <= mem[ram_addr];
      else begin
        mem[ram_addr] <= ram_din;
        wcount        <= wcount + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          low_cnt, ack_cnt, first_low, hi_cnt, w0;
  logic        got, resumed, stalled;
  logic [7:0]  rd_val, cpu_val;
  logic [15:0] csum_exp;

  initial begin
    reset = 1'b0; cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_hold = 1'b0;
    repeat (3) step();
    check("rst_rdy",   cpu_rdy,    1);
    check("rst_ack",   host_ack,   0);
    check("rst_owns",  host_owns,  0);
    check("rst_rdata", host_rdata, 0);
    check("rst_csum",  host_csum,  0);
    reset = 1'b1;
    step();

    // CPU-only write then read-back; RAM sees the CPU cycle verbatim.
    cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 15'h0200; cpu_wdata = 8'h5A;
    #1;
    check("cpu_ram_cs",   ram_cs,   1);
    check("cpu_ram_rw",   ram_rw,   0);
    check("cpu_ram_addr", ram_addr, 15'h0200);
    check("cpu_ram_din",  ram_din,  8'h5A);
    step();
    cpu_rw = 1'b1;
    step();
    check("cpu_rd_0200", ram_dout, 8'h5A);
    check("cpu_rdy_idle", cpu_rdy, 1);
    cpu_rw = 1'b0; cpu_addr = 15'h0010; cpu_wdata = 8'h33;
    step();
    cpu_cs = 1'b0; cpu_rw = 1'b1;
    step();

    // Single host write: 4 stalled cycles, one ack.
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h1000; host_wdata = 8'hA5;
    low_cnt = 0; ack_cnt = 0; first_low = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!cpu_rdy) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
      if (host_ack) begin
        ack_cnt++;
        host_req = 1'b0;
      end
    end
    check("hw_stall_cycles", low_cnt, 4);
    check("hw_first_low",    first_low, 1);
    check("hw_acks",         ack_cnt, 1);
    host_we = 1'b0;
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 15'h1000;
    step();
    check("cpu_rd_1000", ram_dout, 8'hA5);
    cpu_cs = 1'b0;
    step();

    // CPU write collides with a host read request, then CPU reads 0x0010 while stalled.
    w0 = wcount;
    cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 15'h0020; cpu_wdata = 8'h77;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0200;
    step();
    cpu_rw = 1'b1; cpu_addr = 15'h0010;
    ack_cnt = 0; resumed = 1'b0; rd_val = '0; cpu_val = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (host_ack) begin
        ack_cnt++;
        rd_val = host_rdata;
        host_req = 1'b0;
      end
      if (ack_cnt > 0 && cpu_rdy && !resumed) begin
        resumed = 1'b1;
        cpu_val = ram_dout;
      end
    end
    check("hr_acks",        ack_cnt, 1);
    check("hr_rdata",       rd_val, 8'h5A);
    check("hr_cpu_resumed", resumed, 1);
    check("hr_cpu_data",    cpu_val, 8'h33);
    check("hr_cpu_writes",  wcount - w0, 1);
    check("hr_mem_0020",    mem[15'h0020], 8'h77);
    cpu_cs = 1'b0;
    step();

    // Held burst of 16 writes.
    host_hold = 1'b1; ack_cnt = 0; hi_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      host_req = 1'b1; host_we = 1'b1;
      host_addr = 15'h0300 + 15'(k); host_wdata = 8'(k);
      got = 1'b0;
      for (int j = 0; j < 10 && !got; j++) begin
        step();
        if (ack_cnt > 0 && cpu_rdy) hi_cnt++;
        if (host_ack) begin
          got = 1'b1;
          ack_cnt++;
        end
      end
      host_req = 1'b0;
      step();
      if (cpu_rdy) hi_cnt++;
    end
`ifdef AIM65_RAM_ARB_CSUM_EN
    csum_exp = 16'h0078;
`else
    csum_exp = 16'h0000;
`endif
    check("burst_acks",     ack_cnt, 16);
    check("burst_rdy_high", hi_cnt, 0);
    check("burst_owns",     host_owns, 1);
    check("burst_csum",     host_csum, csum_exp);
    check("burst_mem_0307", mem[15'h0307], 8'h07);
    check("burst_mem_030F", mem[15'h030F], 8'h0F);
    host_hold = 1'b0;
    got = 1'b0;
    for (int j = 0; j < 10 && !got; j++) begin
      step();
      if (cpu_rdy) got = 1'b1;
    end
    check("burst_release", got, 1);

    // Request held after ack is not re-executed.
    w0 = wcount;
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0400; host_wdata = 8'h11;
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (host_ack) ack_cnt++;
    end
    check("held_acks",   ack_cnt, 1);
    check("held_writes", wcount - w0, 1);
    host_req = 1'b0; host_we = 1'b0;
    step();

    // Two reads separated by one idle cycle: slot rule gives 3 CPU-ready cycles.
    host_req = 1'b1; host_addr = 15'h0400;
    got = 1'b0; rd_val = '0;
    for (int j = 0; j < 10 && !got; j++) begin
      step();
      if (host_ack) begin
        got = 1'b1;
        rd_val = host_rdata;
      end
    end
    check("slot_first_ack", got, 1);
    check("slot_rd_0400",   rd_val, 8'h11);
    host_req = 1'b0;
    step();
    host_req = 1'b1; host_addr = 15'h0300;
    hi_cnt = 0; stalled = 1'b0;
    for (int j = 0; j < 20 && !stalled; j++) begin
      step();
      if (cpu_rdy) hi_cnt++;
      else if (hi_cnt > 0) stalled = 1'b1;
    end
    check("slot_stalled",  stalled, 1);
    check("slot_rdy_gap",  hi_cnt, 3);
    got = 1'b0; rd_val = 8'hFF;
    for (int j = 0; j < 10 && !got; j++) begin
      step();
      if (host_ack) begin
        got = 1'b1;
        rd_val = host_rdata;
      end
    end
    check("slot_second_ack", got, 1);
    check("slot_rd_0300",    rd_val, 8'h00);
    host_req = 1'b0;
    repeat (5) step();

    // Reset asserted while the host access is on the RAM bus.
    w0 = wcount;
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0500; host_wdata = 8'h99;
    step();
    step();
    check("rst_mid_host_cs",   ram_cs, 1);
    check("rst_mid_host_addr", ram_addr, 15'h0500);
    reset = 1'b0;
    #1;
    check("rst_mid_rdy",  cpu_rdy, 1);
    check("rst_mid_ack",  host_ack, 0);
    check("rst_mid_owns", host_owns, 0);
    check("rst_mid_cs",   ram_cs, 0);
    check("rst_mid_csum", host_csum, 0);
    host_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (host_ack) ack_cnt++;
    end
    check("rst_mid_no_ack",   ack_cnt, 0);
    check("rst_mid_no_write", wcount - w0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aim65_ram_arbiter.md
Name: aim65_ram_arbiter

Overview:
Shares the 32 KB system RAM (synchronous, 1-cycle read latency) between the 65C02 and a host loader port (program download and read-back from the MiSTer side).
- The CPU owns the RAM by default.
- A host access stalls the CPU via RDY, runs one host cycle, then re-presents the stalled CPU address so the CPU resumes with valid read data.
- Sits between aim65_decmux/cpu_65c02 and the ram instance.

Parameters:
ADDR_WIDTH, 15, RAM address width.
DATA_WIDTH, 8, RAM data width.
CPU_SLOTS, 2, minimum CPU-owned cycles between host grants when host_hold=0; 0 = no guarantee.

Ports:
cpu_clk  input  1  single clock, shared with CPU and RAM.
reset  input  1  asynchronous, active-low reset (0 = in reset).
cpu_cs  input  1  RAM select from decoder.
cpu_rw  input  1  CPU direction, 1 = read.
cpu_addr  input  ADDR_WIDTH  CPU address.
cpu_wdata  input  DATA_WIDTH  CPU write data.
cpu_rdy  output  1  to CPU RDY; 0 stalls CPU.
host_req  input  1  level request, held until host_ack.
host_we  input  1  1 = write, 0 = read.
host_addr  input  ADDR_WIDTH  host address.
host_wdata  input  DATA_WIDTH  host write data.
host_hold  input  1  keep CPU stalled across a host burst.
host_ack  output  1  one-cycle completion pulse.
host_rdata  output  DATA_WIDTH  read data, valid while host_ack=1.
host_owns  output  1  1 while CPU is stalled by arbiter.
ram_cs  output  1  to RAM.
ram_rw  output  1  to RAM, 1 = read.
ram_addr  output  ADDR_WIDTH  to RAM.
ram_din  output  DATA_WIDTH  to RAM write data.
ram_dout  input  DATA_WIDTH  from RAM, valid the cycle after a read access.
host_csum  output  16  host write checksum; see Optional Feature.

Behaviour:
- Reset values: state CPU, cpu_rdy=1, host_ack=0, host_rdata=0, host_owns=0, slot counter=CPU_SLOTS, req_armed=1, host_csum=0.
- cpu_rdy, host_ack, host_rdata and host_owns are registered. ram_* outputs are a combinational mux on state.
- RAM mux:
  - CPU/STALL/REPLAY: addr/din from CPU.
  - HOST: addr/din/rw from host (rw = ~host_we), cs=1.
  - HDONE/HIDLE: cs=0.
- ram_cs per state: CPU → cpu_cs; STALL → 0; REPLAY → cpu_cs with ram_rw forced 1. A CPU write is never committed twice.
- States and transitions:
  - CPU: cpu_rdy=1. Slot counter increments and saturates at CPU_SLOTS. Go to STALL when host_req & req_armed & counter==CPU_SLOTS.
  - STALL: cpu_rdy=0, host_owns=1. Go to HOST.
  - HOST: one RAM access for the host. Go to HDONE.
  - HDONE: host_ack=1; host_rdata=ram_dout on reads, unchanged on writes; req_armed cleared. Go to HIDLE if host_hold, else REPLAY.
  - HIDLE: CPU stays stalled. Go to HOST if host_req & req_armed; go to REPLAY if host_hold=0.
  - REPLAY: stalled CPU address re-read. Go to CPU with cpu_rdy=1 on the next edge; counter cleared to 0.
- Timing: req sampled high at edge N (state CPU) → cpu_rdy low after N+1 → host access cycle N+2 → ack cycle N+3 → REPLAY N+4 → cpu_rdy high after N+5. Single host access costs the CPU 4 stalled cycles.
- req_armed is set on any edge where host_req=0. A request still high after its ack is therefore never re-executed; the host must drop req for ≥1 cycle between transactions.
- Simultaneous events:
  - host_req high while cpu_cs=1 and the CPU is writing: the CPU write in that cycle completes. The grant takes effect next cycle.
  - host_hold dropped in HDONE: goes to REPLAY.
  - host_req rising in REPLAY: waits until back in CPU and slot rule satisfied.
- CPU_SLOTS=0: back-to-back grants allowed. The CPU still gets ≥1 cycle (CPU state) between non-held transactions.
- Reset mid-transaction: immediately CPU state, cpu_rdy=1, ack suppressed. The host must re-issue.
- Address wrap: addresses are used modulo 2^ADDR_WIDTH; no bounds check.

Optional Feature:
AIM65_RAM_ARB_CSUM_EN:
- Defined: host_csum accumulates host write data (zero-extended) modulo 2^16 on each HOST write cycle. Cleared on reset and on the rising edge of host_hold. Reads do not affect it.
- Undefined: host_csum is tied to 16'h0000 and no accumulator is built.

Test Plan:
- CPU-only reads/writes, host idle → cpu_rdy stays 1; RAM sees exact CPU cycles; write 8'h5A@15'h0200 reads back 8'h5A.
- Single host write 8'hA5@15'h1000 → cpu_rdy low exactly 4 cycles; host_ack pulses once; CPU read of 15'h1000 returns 8'hA5.
- CPU mid-read of 15'h0010 (=8'h33) when host read arrives → CPU resumes with 8'h33; host_rdata equals RAM content; no extra CPU write occurs.
- host_hold=1 burst of 16 writes 8'h00..8'h0F to 15'h0300.. → cpu_rdy low for the whole burst; 16 acks; with CSUM_EN host_csum=16'h0078.
- host_req held high after ack → no second access until req drops; CPU_SLOTS=2 enforces ≥2 cycles with cpu_rdy=1 between grants.
- Reset asserted in HOST state → cpu_rdy=1, host_ack=0, state CPU immediately; no ack after release.
